// File: rtl/data_sram_resp_pkg.sv
// Shared definitions for the data SRAM responder: FSM encodings, the default depth
// and the byte-lane merge used by the bank.
package data_sram_resp_pkg;

  typedef enum logic {
    DSRAM_CLEAR = 1'b0,
    DSRAM_READY = 1'b1
  } dsram_state_e;

  localparam int DSRAM_ADDR_W = 12;
  localparam int DSRAM_LANES  = 4;
  localparam int DSRAM_LANE_W = 8;

  // Bytes whose enable is set come from new_word, the rest keep old_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < DSRAM_LANES; i++) begin
      mask[i*DSRAM_LANE_W +: DSRAM_LANE_W] = {DSRAM_LANE_W{be[i]}};
    end
    return (old_word & ~mask) | (new_word & mask);
  endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// CPU data SRAM request/response bus: the EXE stage is the master, the RAM responder
// is the slave.
interface data_sram_resp_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_resp_bank.sv
// dsram_bank: 2^ADDR_W x 32 array with byte write enables and a registered read port
// that is either read-first or write-first depending on WRITE_FIRST.
module dsram_bank
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_W      = DSRAM_ADDR_W,
  parameter bit WRITE_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        wr_be,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  input  logic              rd_en,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] old_word;
  logic [31:0] merged;

  assign old_word = mem[idx];
  assign merged   = merge_lanes(old_word, wdata, wr_be);

  always_ff @(posedge clk) begin
    if (|wr_be) begin
      mem[idx] <= merged;
    end
  end

  // With no lanes enabled merged equals old_word, so reads behave the same either way.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= WRITE_FIRST ? merged : old_word;
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// data_sram_resp: data RAM responder with post-reset clear sequencer and saturating
// access counters. Define DSRAM_WRITE_FIRST_EN for write-first read data on writes.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_W = DSRAM_ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  data_sram_resp_if.slave      bus,
  output logic                 init_done,
  output logic [CNT_W-1:0]     rd_cnt,
  output logic [CNT_W-1:0]     wr_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);

`ifdef DSRAM_WRITE_FIRST_EN
  localparam bit WRITE_FIRST = 1'b1;
`else
  localparam bit WRITE_FIRST = 1'b0;
`endif

  dsram_state_e      state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
  logic [ADDR_W-1:0] req_idx;
  logic [ADDR_W-1:0] bank_idx;
  logic [3:0]        bank_be;
  logic [31:0]       bank_wdata;
  logic              bank_rd;
  logic              acc_rd, acc_wr, acc_drop;
  logic              unused_addr_bits;

  assign req_idx          = bus.data_sram_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{bus.data_sram_addr[31:ADDR_W+2], bus.data_sram_addr[1:0]};
  assign init_done        = (state == DSRAM_READY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= DSRAM_CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // The clear pointer owns the array while clearing; requests then only bump drop_cnt.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    bank_be     = '0;
    bank_idx    = req_idx;
    bank_wdata  = bus.data_sram_wdata;
    bank_rd     = 1'b0;
    acc_rd      = 1'b0;
    acc_wr      = 1'b0;
    acc_drop    = 1'b0;
    if (!reset) begin
      case (state)
        DSRAM_CLEAR: begin
          bank_be     = 4'hF;
          bank_idx    = clr_ptr;
          bank_wdata  = '0;
          clr_ptr_nxt = clr_ptr + ADDR_W'(1);
          acc_drop    = bus.data_sram_en;
          if (clr_ptr == '1) begin
            state_nxt = DSRAM_READY;
          end
        end
        DSRAM_READY: begin
          if (bus.data_sram_en) begin
            bank_be = bus.data_sram_we;
            bank_rd = 1'b1;
            acc_rd  = (bus.data_sram_we == 4'h0);
            acc_wr  = (bus.data_sram_we != 4'h0);
          end
        end
        default: state_nxt = DSRAM_CLEAR;
      endcase
    end
  end

  dsram_bank #(
    .ADDR_W      (ADDR_W),
    .WRITE_FIRST (WRITE_FIRST)
  ) u_bank (
    .clk   (clk),
    .reset (reset),
    .wr_be (bank_be),
    .idx   (bank_idx),
    .wdata (bank_wdata),
    .rd_en (bank_rd),
    .rdata (bus.data_sram_rdata)
  );

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (acc_rd && (rd_cnt != '1)) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
      if (acc_wr && (wr_cnt != '1)) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
      end
      if (acc_drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench for data_sram_resp (ADDR_W=4, CNT_W=3): directed plan cases plus
// randomized traffic against a word-array reference model.
module tb_data_sram_resp;

  localparam int ADDR_W  = 4;
  localparam int CNT_W   = 3;
  localparam int DEPTH   = 16;
  localparam int CNT_MAX = 7;
`ifdef DSRAM_WRITE_FIRST_EN
  localparam bit WRITE_FIRST = 1'b1;
`else
  localparam bit WRITE_FIRST = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             init_done;
  logic [CNT_W-1:0] rd_cnt, wr_cnt, drop_cnt;

  data_sram_resp_if bus ();

  data_sram_resp #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .init_done (init_done),
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdata;
  int          model_rd, model_wr, model_drop, clear_cycles;
  bit          model_done;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic int satInc(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  // Reference behaviour for one clock edge, straight from the block's rules.
  task automatic modelEdge(input bit r, input bit en, input logic [3:0] we,
                           input logic [31:0] addr, input logic [31:0] wdata);
    int          idx;
    logic [31:0] old_word, new_word;
    if (r) begin
      model_rdata  = 32'h0;
      model_rd     = 0;
      model_wr     = 0;
      model_drop   = 0;
      clear_cycles = 0;
      model_done   = 1'b0;
    end else if (!model_done) begin
      if (en) model_drop = satInc(model_drop);
      model_mem[clear_cycles] = 32'h0;
      clear_cycles++;
      if (clear_cycles == DEPTH) model_done = 1'b1;
    end else if (en) begin
      idx      = int'((addr >> 2) % DEPTH);
      old_word = model_mem[idx];
      new_word = old_word;
      for (int i = 0; i < 4; i++) begin
        if (we[i]) new_word[8*i +: 8] = wdata[8*i +: 8];
      end
      model_mem[idx] = new_word;
      model_rdata    = WRITE_FIRST ? new_word : old_word;
      if (we == 4'h0) model_rd = satInc(model_rd);
      else            model_wr = satInc(model_wr);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".rdata"},     bus.data_sram_rdata, model_rdata);
    checkOutput({tag, ".init_done"}, 32'(init_done), 32'(model_done));
    checkOutput({tag, ".rd_cnt"},    32'(rd_cnt),    32'(model_rd));
    checkOutput({tag, ".wr_cnt"},    32'(wr_cnt),    32'(model_wr));
    checkOutput({tag, ".drop_cnt"},  32'(drop_cnt),  32'(model_drop));
  endtask

  task automatic applyStimulus(input bit r, input bit en, input logic [3:0] we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input string tag);
    reset               = r;
    bus.data_sram_en    = en;
    bus.data_sram_we    = we;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
    @(posedge clk);
    modelEdge(r, en, we, addr, wdata);
    @(negedge clk);
    checkAll(tag);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    model_rdata = 32'h0;

    applyStimulus(1, 0, 4'h0, 32'h0, 32'h0, "reset");
    applyStimulus(1, 0, 4'h0, 32'h0, 32'h0, "reset");
    checkOutput("reset_rdata", bus.data_sram_rdata, 32'h0);
    checkOutput("reset_init_done", 32'(init_done), 32'h0);

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, "clear");
      if (i == DEPTH - 2) checkOutput("init_low_16", 32'(init_done), 32'h0);
      if (i == DEPTH - 1) checkOutput("init_high_17", 32'(init_done), 32'h1);
    end

    applyStimulus(0, 1, 4'h0, 32'h3C, 32'h0, "read3C");
    checkOutput("plan_read3C", bus.data_sram_rdata, 32'h0);
    checkOutput("plan_rd_cnt1", 32'(rd_cnt), 32'h1);

    applyStimulus(0, 1, 4'hF, 32'h8, 32'hDEADBEEF, "wr8");
    applyStimulus(0, 1, 4'h0, 32'h8, 32'h0, "rd8");
    checkOutput("plan_full_write", bus.data_sram_rdata, 32'hDEADBEEF);
    applyStimulus(0, 1, 4'h0, 32'h0004_0008, 32'h0, "rd_alias");
    checkOutput("plan_alias", bus.data_sram_rdata, 32'hDEADBEEF);

    applyStimulus(0, 1, 4'b0101, 32'h8, 32'h11223344, "wr_partial");
    applyStimulus(0, 1, 4'h0, 32'h8, 32'h0, "rd_partial");
    checkOutput("plan_partial", bus.data_sram_rdata, 32'hDE22BE44);
    checkOutput("plan_wr_cnt2", 32'(wr_cnt), 32'h2);

    applyStimulus(0, 1, 4'hF, 32'h10, 32'hCAFEF00D, "wr_resp");
    checkOutput("plan_write_resp", bus.data_sram_rdata,
                WRITE_FIRST ? 32'hCAFEF00D : 32'h0);

    applyStimulus(1, 0, 4'h0, 32'h0, 32'h0, "reset2");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 4'($urandom_range(0, 15)), $urandom, $urandom, "drop");
    end
    checkOutput("plan_drop_cnt5", 32'(drop_cnt), 32'h5);
    checkOutput("plan_drop_rdata", bus.data_sram_rdata, 32'h0);
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, "clear_mid");
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, "clear_mid");
    applyStimulus(1, 0, 4'h0, 32'h0, 32'h0, "reset_mid");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, "reclear");
      if (i == DEPTH - 2) checkOutput("reclear_low", 32'(init_done), 32'h0);
      if (i == DEPTH - 1) checkOutput("reclear_high", 32'(init_done), 32'h1);
    end

    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 1, 4'h0, $urandom, 32'h0, "sat_read");
    end
    checkOutput("plan_rd_sat", 32'(rd_cnt), 32'h7);
    checkOutput("plan_cleared_after_reset", bus.data_sram_rdata, 32'h0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 149) == 0, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                    $urandom, $urandom, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
